mem_stage_lsu: RTL and testbench
================================

Name: mem_stage_lsu

Overview:
Parametrised successor to the pipeline memory stage. It accepts one load/store/pass-through op per handshake and issues a single aligned data-memory request. It waits a variable number of cycles for dmem_resp, then aligns and sign/zero-extends load data. Results go to writeback over a valid/ready handshake. It adds stall-tolerant multi-cycle memory, misalignment detection and 64-bit support, none of which the single-cycle stage has.

Parameters:
DATA_W, 32, data/register width; legal values 32 or 64.
ADDR_W, 32, address width.
TAG_W, 64, opaque sideband passed through unchanged (pc/order/wb ctrl).
STRB_W, DATA_W/8, byte-strobe width (derived, not overridable).

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
in_valid  in  1  upstream op valid
in_ready  out  1  stage can accept op
in_re  in  1  op is load
in_we  in  1  op is store (in_re and in_we both set: treated as store)
in_funct3  in  3  RV load/store funct3
in_addr  in  ADDR_W  effective address (alu_out)
in_wdata  in  DATA_W  store data (rs2_v)
in_rd  in  5  destination register
in_tag  in  TAG_W  sideband
dmem_addr  out  ADDR_W  request address, low log2(STRB_W) bits zero
dmem_rmask  out  STRB_W  read byte mask
dmem_wmask  out  STRB_W  write byte mask
dmem_wdata  out  DATA_W  lane-shifted store data
dmem_rdata  in  DATA_W  full-word read data
dmem_resp  in  1  request complete
out_valid  out  1  result valid
out_ready  in  1  writeback accepts
out_rd  out  5  registered in_rd
out_rdata  out  DATA_W  extended load data; 0 for store/pass-through/misaligned
out_tag  out  TAG_W  registered in_tag
out_misaligned  out  1  access not naturally aligned

Behaviour:
- Reset (rst low, async): state IDLE; out_valid=0, dmem_rmask=0, dmem_wmask=0, dmem_addr=0, dmem_wdata=0, out_rdata=0, out_misaligned=0, out_rd=0, out_tag=0.
- States IDLE, REQ, WAIT, OUT. in_ready=1 in IDLE, or in OUT while out_ready=1; 0 otherwise.
- Accept = in_valid & in_ready; latch all in_* fields.
- Accepted op that is a memory op and aligned -> REQ. Pass-through op or misaligned op -> OUT, with no dmem request.
- Funct3 codes: 000 b, 001 h, 010 w, 011 d; loads also 100 bu, 101 hu, 110 wu.
- Codes d and wu are illegal when DATA_W=32. An illegal funct3 is treated as misaligned: out_misaligned=1, no request.
- Alignment: h needs addr[0]=0; w needs addr[1:0]=0; d needs addr[2:0]=0.
- REQ (exactly 1 cycle):
  - dmem_addr = addr with low log2(STRB_W) bits cleared.
  - Mask = (1/3/15/255 for b/h/w/d) << addr offset, on dmem_rmask for loads and dmem_wmask for stores; the other mask is 0.
  - dmem_wdata = in_wdata << (8*offset); unused lanes are 0.
  - Next state WAIT.
- WAIT: masks=0, dmem_addr/dmem_wdata held. On dmem_resp go to OUT. For loads, out_rdata = selected lane of dmem_rdata: sign-extended for b/h/w, zero-extended for bu/hu/wu, full lane for d (or w at DATA_W=32).
- dmem_resp outside WAIT is ignored. Latency is unbounded; there is no timeout.
- OUT: out_valid=1, and all out_* fields stay stable until out_ready.
  - out_ready=1 with no new accept -> IDLE.
  - out_ready=1 with a simultaneous accept -> REQ or OUT per the new op. Zero bubble for back-to-back pass-through ops.
- Minimum latency, accept to out_valid: pass-through/misaligned 1 cycle; memory op 2 cycles + response wait (resp in first WAIT cycle -> out_valid 3 cycles after accept).
- Reset asserted in REQ/WAIT abandons the op. A late dmem_resp after reset release is ignored (state IDLE).
- At most one outstanding dmem request at any time.

Test Plan:
- DATA_W=32, lb addr 0x1003, resp after 2 WAIT cycles, rdata 0x80FF_FF12 -> rmask 4'b1000, dmem_addr 0x1000; out_rdata 0xFFFF_FF80; out_valid 4 cycles after accept.
- sh addr 0x2002, in_wdata 0x0000_ABCD, resp immediate -> wmask 4'b1100, dmem_wdata 0xABCD_0000, rmask 0; out_rdata 0.
- lw addr 0x3001 -> no dmem mask asserted; out_valid next cycle, out_misaligned=1, out_rdata 0.
- DATA_W=64, lwu addr 0x4004, rdata 0x8765_4321_0000_0000 -> rmask 8'hF0, out_rdata 0x0000_0000_8765_4321; ld at 0x4004 -> misaligned.
- Back-pressure: out_ready=0 for 5 cycles then 1, new pass-through op waiting -> out_* stable throughout; in_ready=0 until the release cycle; next op out_valid the cycle after.
- rst low during WAIT, dmem_resp pulsed 2 cycles after release -> all outputs at reset values; no out_valid generated.

Source files
------------

// File: rtl/mem_stage_lsu_if.sv
`default_nettype none
// ============================================================================
//  Module   : mem_stage_lsu_if
//  Purpose  : Bundles the three handshakes of the load/store memory stage:
//             upstream op (in_*), data-memory request/response (dmem_*) and
//             writeback result (out_*).
//  Modports : slave  - the memory stage itself
//             master - the environment around it (pipeline, memory, WB)
//  Revision : 1.0 - initial release
// ============================================================================
interface mem_stage_lsu_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int TAG_W  = 64
);
  localparam int STRB_W = DATA_W / 8;

  // upstream op
  logic              in_valid;
  logic              in_ready;
  logic              in_re;
  logic              in_we;
  logic [2:0]        in_funct3;
  logic [ADDR_W-1:0] in_addr;
  logic [DATA_W-1:0] in_wdata;
  logic [4:0]        in_rd;
  logic [TAG_W-1:0]  in_tag;
  // data memory
  logic [ADDR_W-1:0] dmem_addr;
  logic [STRB_W-1:0] dmem_rmask;
  logic [STRB_W-1:0] dmem_wmask;
  logic [DATA_W-1:0] dmem_wdata;
  logic [DATA_W-1:0] dmem_rdata;
  logic              dmem_resp;
  // writeback
  logic              out_valid;
  logic              out_ready;
  logic [4:0]        out_rd;
  logic [DATA_W-1:0] out_rdata;
  logic [TAG_W-1:0]  out_tag;
  logic              out_misaligned;

  modport slave (
    input  in_valid, in_re, in_we, in_funct3, in_addr, in_wdata, in_rd, in_tag,
    input  dmem_rdata, dmem_resp, out_ready,
    output in_ready, dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
    output out_valid, out_rd, out_rdata, out_tag, out_misaligned
  );

  modport master (
    output in_valid, in_re, in_we, in_funct3, in_addr, in_wdata, in_rd, in_tag,
    output dmem_rdata, dmem_resp, out_ready,
    input  in_ready, dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
    input  out_valid, out_rd, out_rdata, out_tag, out_misaligned
  );
endinterface
`default_nettype wire

// File: rtl/mem_stage_lsu.sv
`default_nettype none
// ============================================================================
//  Module   : mem_stage_lsu
//  Purpose  : Pipeline memory stage. Accepts one load/store/pass-through op
//             per handshake, issues at most one aligned data-memory request,
//             waits any number of cycles for dmem_resp, then aligns and
//             sign/zero-extends load data and hands the result to writeback.
//             Misaligned or illegal-width accesses skip memory and are flagged.
//  Ports    : clk  - clock
//             rst  - asynchronous reset, active LOW
//             bus  - mem_stage_lsu_if.slave (in_*, dmem_*, out_* signals)
//  Params   : DATA_W (32 or 64), ADDR_W, TAG_W
//  Revision : 1.0 - initial release
// ============================================================================
module mem_stage_lsu #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int TAG_W  = 64
) (
  input  logic           clk,
  input  logic           rst,
  mem_stage_lsu_if.slave bus
);

  localparam int STRB_W = DATA_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next;

  logic              w_in_ready;
  logic              w_accept;
  logic              w_mem;
  logic              w_store;
  logic              w_illegal;
  logic              w_unaligned;
  logic              w_mis;
  logic              w_go_req;
  logic [OFF_W-1:0]  w_off;
  logic [STRB_W-1:0] w_base;
  logic [STRB_W-1:0] w_mask;
  logic [DATA_W-1:0] w_lane_bits;
  logic [DATA_W-1:0] w_wdata;
  logic [DATA_W-1:0] w_lane;
  logic [DATA_W-1:0] w_ld;

  logic [2:0]        r_funct3;
  logic [OFF_W-1:0]  r_off;
  logic              r_load;
  logic [4:0]        r_rd;
  logic [TAG_W-1:0]  r_tag;
  logic              r_mis;
  logic [DATA_W-1:0] r_rdata;
  logic [ADDR_W-1:0] r_daddr;
  logic [DATA_W-1:0] r_dwdata;
  logic [STRB_W-1:0] r_rmask;
  logic [STRB_W-1:0] r_wmask;

  // --------------------------------------------------------------------------
  // Upstream handshake and op decode
  // --------------------------------------------------------------------------
  assign w_in_ready = (r_state == S_IDLE) || ((r_state == S_OUT) && bus.out_ready);
  assign w_accept   = bus.in_valid && w_in_ready;
  // A set in_we wins over in_re: such an op is a store.
  assign w_store    = bus.in_we;
  assign w_mem      = bus.in_re || bus.in_we;
  assign w_off      = bus.in_addr[OFF_W-1:0];

  always_comb begin
    w_base      = '0;
    w_unaligned = 1'b0;
    w_illegal   = 1'b0;
    case (bus.in_funct3[1:0])
      2'b00: w_base = STRB_W'(1);
      2'b01: begin
        w_base      = STRB_W'(3);
        w_unaligned = bus.in_addr[0];
      end
      2'b10: begin
        w_base      = STRB_W'(15);
        w_unaligned = |bus.in_addr[1:0];
      end
      default: begin
        w_base      = '1;
        w_unaligned = |bus.in_addr[2:0];
        w_illegal   = (DATA_W == 32);
      end
    endcase
    // Unsigned variants exist only for loads; wu needs a 64-bit datapath
    // and 111 is never legal.
    if (bus.in_funct3[2]) begin
      if (w_store || (bus.in_funct3[1:0] == 2'b11) ||
          ((bus.in_funct3[1:0] == 2'b10) && (DATA_W == 32))) begin
        w_illegal = 1'b1;
      end
    end
  end

  // Illegal encodings are reported exactly like misalignment.
  assign w_mis    = w_mem && (w_illegal || w_unaligned);
  assign w_go_req = w_mem && !w_mis;
  assign w_mask   = w_base << w_off;

  // Byte-enable expanded to bits, so lanes outside the access size are
  // zeroed before the store data is shifted into position.
  for (genvar gi = 0; gi < STRB_W; gi++) begin : g_lane_bits
    assign w_lane_bits[8*gi +: 8] = {8{w_base[gi]}};
  end

  assign w_wdata = (bus.in_wdata & w_lane_bits) << {w_off, 3'b000};

  // --------------------------------------------------------------------------
  // Load data alignment and extension
  // --------------------------------------------------------------------------
  assign w_lane = bus.dmem_rdata >> {r_off, 3'b000};

  always_comb begin
    w_ld = w_lane;
    case (r_funct3)
      3'b000:  w_ld = DATA_W'($signed(w_lane[7:0]));
      3'b001:  w_ld = DATA_W'($signed(w_lane[15:0]));
      3'b010:  w_ld = DATA_W'($signed(w_lane[31:0]));
      3'b100:  w_ld = DATA_W'(w_lane[7:0]);
      3'b101:  w_ld = DATA_W'(w_lane[15:0]);
      3'b110:  w_ld = DATA_W'(w_lane[31:0]);
      default: w_ld = w_lane;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next = w_go_req ? S_REQ : S_OUT;
        end
      end
      S_REQ:  w_next = S_WAIT;
      S_WAIT: begin
        if (bus.dmem_resp) begin
          w_next = S_OUT;
        end
      end
      default: begin
        if (bus.out_ready) begin
          if (w_accept) begin
            w_next = w_go_req ? S_REQ : S_OUT;
          end else begin
            w_next = S_IDLE;
          end
        end
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_funct3 <= '0;
      r_off    <= '0;
      r_load   <= 1'b0;
      r_rd     <= '0;
      r_tag    <= '0;
      r_mis    <= 1'b0;
      r_rdata  <= '0;
      r_daddr  <= '0;
      r_dwdata <= '0;
      r_rmask  <= '0;
      r_wmask  <= '0;
    end else begin
      // Masks are a one-cycle strobe; address and data stay put.
      if (r_state == S_REQ) begin
        r_rmask <= '0;
        r_wmask <= '0;
      end
      if (w_accept) begin
        r_funct3 <= bus.in_funct3;
        r_off    <= w_off;
        r_load   <= bus.in_re && !bus.in_we;
        r_rd     <= bus.in_rd;
        r_tag    <= bus.in_tag;
        r_mis    <= w_mis;
        r_rdata  <= '0;
        if (w_go_req) begin
          r_daddr  <= {bus.in_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
          r_dwdata <= w_wdata;
          r_rmask  <= w_store ? '0 : w_mask;
          r_wmask  <= w_store ? w_mask : '0;
        end
      end
      if ((r_state == S_WAIT) && bus.dmem_resp && r_load) begin
        r_rdata <= w_ld;
      end
    end
  end

  assign bus.in_ready       = w_in_ready;
  assign bus.dmem_addr      = r_daddr;
  assign bus.dmem_rmask     = r_rmask;
  assign bus.dmem_wmask     = r_wmask;
  assign bus.dmem_wdata     = r_dwdata;
  assign bus.out_valid      = (r_state == S_OUT);
  assign bus.out_rd         = r_rd;
  assign bus.out_rdata      = r_rdata;
  assign bus.out_tag        = r_tag;
  assign bus.out_misaligned = r_mis;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_lsu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_stage_lsu
//  Purpose  : Scoreboard bench for mem_stage_lsu. A 32-bit and a 64-bit
//             instance share one set of stimulus signals; sel picks which
//             one receives in_valid and whose outputs are observed.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_stage_lsu;

  typedef struct {
    logic        re;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [4:0]  rd;
    logic [63:0] exp_rdata;
    logic        exp_mis;
    int          lat;
    logic [31:0] daddr;
    logic [7:0]  rmask;
    logic [7:0]  wmask;
    logic [63:0] exp_wdata;
    logic [63:0] rdata;
    int          n;
  } vec_t;

  typedef struct {
    logic [63:0] rdata;
    logic [4:0]  rd;
    logic [63:0] tag;
    logic        mis;
    int          lat;
    int          acc;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  rmask;
    logic [7:0]  wmask;
    logic [63:0] wdata;
    logic [63:0] rdata;
    int          n;
  } req_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sel = 1'b0;
  logic        t_valid = 1'b0;
  logic        t_re = 1'b0;
  logic        t_we = 1'b0;
  logic [2:0]  t_f3 = 3'b0;
  logic [31:0] t_addr = 32'b0;
  logic [63:0] t_wdata = 64'b0;
  logic [4:0]  t_rd = 5'b0;
  logic [63:0] t_tag = 64'b0;
  logic        t_oready = 1'b1;
  logic        t_resp = 1'b0;
  logic [63:0] t_rdata = 64'hA5A5_A5A5_A5A5_A5A5;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  exp_t out_q[$];
  req_t req_q[$];
  vec_t v32[14];
  vec_t v64[7];

  mem_stage_lsu_if #(.DATA_W(32), .ADDR_W(32), .TAG_W(64)) if32 ();
  mem_stage_lsu_if #(.DATA_W(64), .ADDR_W(32), .TAG_W(64)) if64 ();

  mem_stage_lsu #(.DATA_W(32), .ADDR_W(32), .TAG_W(64)) u_dut32 (
    .clk (clk), .rst (rst), .bus (if32)
  );
  mem_stage_lsu #(.DATA_W(64), .ADDR_W(32), .TAG_W(64)) u_dut64 (
    .clk (clk), .rst (rst), .bus (if64)
  );

  assign if32.in_valid   = t_valid & ~sel;
  assign if32.in_re      = t_re;
  assign if32.in_we      = t_we;
  assign if32.in_funct3  = t_f3;
  assign if32.in_addr    = t_addr;
  assign if32.in_wdata   = t_wdata[31:0];
  assign if32.in_rd      = t_rd;
  assign if32.in_tag     = t_tag;
  assign if32.dmem_rdata = t_rdata[31:0];
  assign if32.dmem_resp  = t_resp;
  assign if32.out_ready  = t_oready;

  assign if64.in_valid   = t_valid & sel;
  assign if64.in_re      = t_re;
  assign if64.in_we      = t_we;
  assign if64.in_funct3  = t_f3;
  assign if64.in_addr    = t_addr;
  assign if64.in_wdata   = t_wdata;
  assign if64.in_rd      = t_rd;
  assign if64.in_tag     = t_tag;
  assign if64.dmem_rdata = t_rdata;
  assign if64.dmem_resp  = t_resp;
  assign if64.out_ready  = t_oready;

  logic        m_in_ready, m_valid, m_mis;
  logic [4:0]  m_rd;
  logic [63:0] m_rdata, m_tag, m_dwdata;
  logic [31:0] m_daddr;
  logic [7:0]  m_rmask, m_wmask;

  assign m_in_ready = sel ? if64.in_ready : if32.in_ready;
  assign m_valid    = sel ? if64.out_valid : if32.out_valid;
  assign m_mis      = sel ? if64.out_misaligned : if32.out_misaligned;
  assign m_rd       = sel ? if64.out_rd : if32.out_rd;
  assign m_rdata    = sel ? if64.out_rdata : {32'b0, if32.out_rdata};
  assign m_tag      = sel ? if64.out_tag : if32.out_tag;
  assign m_dwdata   = sel ? if64.dmem_wdata : {32'b0, if32.dmem_wdata};
  assign m_daddr    = sel ? if64.dmem_addr : if32.dmem_addr;
  assign m_rmask    = sel ? if64.dmem_rmask : {4'b0, if32.dmem_rmask};
  assign m_wmask    = sel ? if64.dmem_wmask : {4'b0, if32.dmem_wmask};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_out_valid"}, 64'(m_valid), 64'd0);
    chk({tag, "_rmask"}, 64'(m_rmask), 64'd0);
    chk({tag, "_wmask"}, 64'(m_wmask), 64'd0);
    chk({tag, "_dmem_addr"}, 64'(m_daddr), 64'd0);
    chk({tag, "_dmem_wdata"}, m_dwdata, 64'd0);
    chk({tag, "_out_rdata"}, m_rdata, 64'd0);
    chk({tag, "_out_mis"}, 64'(m_mis), 64'd0);
    chk({tag, "_out_rd"}, 64'(m_rd), 64'd0);
    chk({tag, "_out_tag"}, m_tag, 64'd0);
  endtask

  // Drive one op, wait (bounded) for acceptance, queue its expectations.
  task automatic issue(input vec_t v);
    bit got = 1'b0;
    t_valid = 1'b1;
    t_re    = v.re;
    t_we    = v.we;
    t_f3    = v.f3;
    t_addr  = v.addr;
    t_wdata = v.wdata;
    t_rd    = v.rd;
    t_tag   = {32'hC0DE_F00D, 27'd0, v.rd};
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (m_in_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout rd=%0d: got in_ready=0 expected in_ready=1", v.rd);
    end else begin
      out_q.push_back('{rdata: v.exp_rdata, rd: v.rd, tag: {32'hC0DE_F00D, 27'd0, v.rd},
                        mis: v.exp_mis, lat: v.lat, acc: cyc});
      if ((v.rmask | v.wmask) != 8'h00)
        req_q.push_back('{addr: v.daddr, rmask: v.rmask, wmask: v.wmask,
                          wdata: v.exp_wdata, rdata: v.rdata, n: v.n});
    end
    @(posedge clk);
    #1;
    t_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 100; k++) begin
      if (out_q.size() == 0 && req_q.size() == 0) break;
      @(negedge clk);
    end
    chk("drain_out_q", 64'(out_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  // Output monitor: compares every valid cycle against the queue head, so
  // held outputs are checked for stability; pops on handshake.
  exp_t mon_e;
  logic prev_v  = 1'b0;
  logic prev_hs = 1'b0;
  always @(negedge clk) begin
    if (m_valid) begin
      if (out_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: got out_valid=1 rd=%0d expected out_valid=0", m_rd);
      end else begin
        mon_e = out_q[0];
        if (!prev_v || prev_hs)
          chk("latency", 64'(cyc - mon_e.acc), 64'(mon_e.lat));
        chk("out_rd", 64'(m_rd), 64'(mon_e.rd));
        chk("out_rdata", m_rdata, mon_e.rdata);
        chk("out_tag", m_tag, mon_e.tag);
        chk("out_misaligned", 64'(m_mis), 64'(mon_e.mis));
        if (t_oready) void'(out_q.pop_front());
      end
    end
    prev_v  = m_valid;
    prev_hs = m_valid & t_oready;
  end

  // Memory model: checks each request, answers after n WAIT cycles.
  req_t rsp_r;
  initial begin
    forever begin
      @(negedge clk);
      if (rst && (m_rmask != 8'h00 || m_wmask != 8'h00)) begin
        if (req_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_req: got rmask=%h wmask=%h expected no request", m_rmask, m_wmask);
        end else begin
          rsp_r = req_q.pop_front();
          chk("dmem_addr", 64'(m_daddr), 64'(rsp_r.addr));
          chk("dmem_rmask", 64'(m_rmask), 64'(rsp_r.rmask));
          chk("dmem_wmask", 64'(m_wmask), 64'(rsp_r.wmask));
          chk("dmem_wdata", m_dwdata, rsp_r.wdata);
          repeat (rsp_r.n) @(posedge clk);
          #1;
          t_resp  = 1'b1;
          t_rdata = rsp_r.rdata;
          @(posedge clk);
          #1;
          t_resp  = 1'b0;
          t_rdata = 64'hA5A5_A5A5_A5A5_A5A5;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    v32 = '{
      '{1'b1,1'b0,3'b000,32'h1003,64'h0,5'd1,64'hFFFF_FF80,1'b0,4,32'h1000,8'h08,8'h00,64'h0,64'h80FF_FF12,2},
      '{1'b0,1'b1,3'b001,32'h2002,64'hABCD,5'd2,64'h0,1'b0,3,32'h2000,8'h00,8'h0C,64'hABCD_0000,64'hDEAD_BEEF,1},
      '{1'b1,1'b0,3'b010,32'h3001,64'h0,5'd3,64'h0,1'b1,1,32'h0,8'h00,8'h00,64'h0,64'h0,0},
      '{1'b1,1'b0,3'b101,32'h1002,64'h0,5'd4,64'h8001,1'b0,3,32'h1000,8'h0C,8'h00,64'h0,64'h8001_7FFF,1},
      '{1'b1,1'b0,3'b001,32'h1002,64'h0,5'd5,64'hFFFF_8001,1'b0,3,32'h1000,8'h0C,8'h00,64'h0,64'h8001_7FFF,1},
      '{1'b1,1'b0,3'b100,32'h1001,64'h0,5'd6,64'h9A,1'b0,3,32'h1000,8'h02,8'h00,64'h0,64'h9A00,1},
      '{1'b0,1'b1,3'b000,32'h5001,64'h1234_5678,5'd7,64'h0,1'b0,3,32'h5000,8'h00,8'h02,64'h7800,64'h0,1},
      '{1'b0,1'b1,3'b010,32'h6000,64'hCAFE_F00D,5'd8,64'h0,1'b0,5,32'h6000,8'h00,8'h0F,64'hCAFE_F00D,64'h0,3},
      '{1'b1,1'b0,3'b010,32'h7000,64'h0,5'd9,64'h89AB_CDEF,1'b0,3,32'h7000,8'h0F,8'h00,64'h0,64'h89AB_CDEF,1},
      '{1'b1,1'b0,3'b011,32'h7000,64'h0,5'd10,64'h0,1'b1,1,32'h0,8'h00,8'h00,64'h0,64'h0,0},
      '{1'b0,1'b0,3'b010,32'h3001,64'hFFFF,5'd11,64'h0,1'b0,1,32'h0,8'h00,8'h00,64'h0,64'h0,0},
      '{1'b1,1'b1,3'b010,32'h8004,64'h1122_3344,5'd12,64'h0,1'b0,3,32'h8004,8'h00,8'h0F,64'h1122_3344,64'h5555_5555,1},
      '{1'b0,1'b1,3'b001,32'h2001,64'hABCD,5'd13,64'h0,1'b1,1,32'h0,8'h00,8'h00,64'h0,64'h0,0},
      '{1'b1,1'b0,3'b110,32'h4004,64'h0,5'd14,64'h0,1'b1,1,32'h0,8'h00,8'h00,64'h0,64'h0,0}
    };
    v64 = '{
      '{1'b1,1'b0,3'b110,32'h4004,64'h0,5'd15,64'h0000_0000_8765_4321,1'b0,3,32'h4000,8'hF0,8'h00,64'h0,64'h8765_4321_0000_0000,1},
      '{1'b1,1'b0,3'b010,32'h4004,64'h0,5'd16,64'hFFFF_FFFF_8765_4321,1'b0,3,32'h4000,8'hF0,8'h00,64'h0,64'h8765_4321_0000_0000,1},
      '{1'b1,1'b0,3'b011,32'h4004,64'h0,5'd17,64'h0,1'b1,1,32'h0,8'h00,8'h00,64'h0,64'h0,0},
      '{1'b1,1'b0,3'b011,32'h4008,64'h0,5'd18,64'h0123_4567_89AB_CDEF,1'b0,3,32'h4008,8'hFF,8'h00,64'h0,64'h0123_4567_89AB_CDEF,1},
      '{1'b0,1'b1,3'b011,32'h4010,64'h1122_3344_5566_7788,5'd19,64'h0,1'b0,3,32'h4010,8'h00,8'hFF,64'h1122_3344_5566_7788,64'h0,1},
      '{1'b0,1'b1,3'b000,32'h4007,64'hFFFF_FFFF_FFFF_FFAB,5'd20,64'h0,1'b0,4,32'h4000,8'h00,8'h80,64'hAB00_0000_0000_0000,64'h0,2},
      '{1'b1,1'b0,3'b001,32'h4006,64'h0,5'd21,64'hFFFF_FFFF_FFFF_BEEF,1'b0,3,32'h4000,8'hC0,8'h00,64'h0,64'hBEEF_0000_0000_0000,1}
    };

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset("rst0");
    chk("rst0_in_ready", 64'(m_in_ready), 64'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;

    // DATA_W = 32 directed ops, issued back to back
    for (int i = 0; i < 14; i++) issue(v32[i]);
    drain();

    // back-pressure: result held 5 cycles while a pass-through op waits
    t_oready = 1'b0;
    issue('{1'b0,1'b0,3'b000,32'h0,64'h0,5'd24,64'h0,1'b0,1,32'h0,8'h00,8'h00,64'h0,64'h0,0});
    fork
      issue('{1'b0,1'b0,3'b000,32'h1,64'h0,5'd25,64'h0,1'b0,1,32'h0,8'h00,8'h00,64'h0,64'h0,0});
      begin
        repeat (5) begin
          @(negedge clk);
          chk("bp_in_ready", 64'(m_in_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        t_oready = 1'b1;
      end
    join
    drain();

    // DATA_W = 64 directed ops
    sel = 1'b1;
    #1;
    for (int i = 0; i < 7; i++) issue(v64[i]);
    drain();
    sel = 1'b0;
    #1;

    // reset during WAIT, late response after release
    issue('{1'b1,1'b0,3'b010,32'h7000,64'h0,5'd26,64'h0,1'b0,3,32'h7000,8'h0F,8'h00,64'h0,64'h1234_5678,6});
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk_reset("rstw");
    out_q.delete();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk_reset("late");
    chk("late_in_ready", 64'(m_in_ready), 64'd1);
    chk("late_req_q", 64'(req_q.size()), 64'd0);
    @(posedge clk);
    #1;

    // recovery after reset
    issue('{1'b0,1'b0,3'b001,32'h9,64'h0,5'd27,64'h0,1'b0,1,32'h0,8'h00,8'h00,64'h0,64'h0,0});
    drain();
    chk("final_req_q", 64'(req_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
